pulse_window_capture: RTL and testbench

Trigger-gated waveform windowing and pulse-height measurement for one ADC channel. Sits between the ADC sample register and the UART framing logic. On a trigger it streams a fixed-length window of samples, measures peak minus pre-trigger pedestal over a configurable leading sub-window, then enforces a hold-off before re-arming. It is the parametrised successor to the fixed 14-bit / 500-sample waveform block, adding a hold-off, clamped arithmetic, a peak index, dropped-trigger counting and optional pedestal averaging.

---
 rtl/pulse_pkg.sv | 26 ++
 rtl/pedestal_avg.sv | 40 ++++
 rtl/pulse_window_capture.sv | 167 ++++++++++++++++
 tb/tb_pulse_window_capture.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// pulse_pkg: shared types and helpers for the pulse_window_capture slice.
//   state_t    : capture FSM state encoding
//   DROP_W     : width of the saturating dropped-trigger counter
//   CALC_W     : working width for the clamped subtract helper
//   clamp_sub  : a - b evaluated one bit wider than the operands, negative -> 0
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam int DROP_W = 8;
  localparam int CALC_W = 32;

  // The extra top bit of the difference is the borrow; a borrow means the
  // peak sat below the pedestal, which is reported as zero height.
  function automatic logic [CALC_W-1:0] clamp_sub(input logic [CALC_W-1:0] a,
                                                  input logic [CALC_W-1:0] b);
    logic [CALC_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[CALC_W] ? '0 : diff[CALC_W-1:0];
  endfunction

endpackage

// File: rtl/pedestal_avg.sv
// pedestal_avg: running mean of the last 2^LOG2 samples taken while en=1.
//   clk      in  sample clock
//   reset_n  in  synchronous active-low reset, clears history and sum
//   en       in  accept 'sample' into the history this cycle
//   sample   in  DATA_W ADC sample
//   pedestal out DATA_W running sum >> LOG2 (truncated)
// Only instantiated when PULSE_PED_AVG_EN is defined.
module pedestal_avg #(
  parameter int DATA_W = 14,
  parameter int LOG2   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] pedestal
);

  localparam int DEPTH = 1 << LOG2;
  localparam int SUM_W = DATA_W + LOG2;

  logic [DATA_W-1:0] hist [DEPTH];
  logic [SUM_W-1:0]  sum;

  // The sum is maintained incrementally: add the newcomer, drop the sample
  // falling off the end of the history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      sum <= '0;
    end else if (en) begin
      hist[0] <= sample;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
      sum <= sum + SUM_W'(sample) - SUM_W'(hist[DEPTH-1]);
    end
  end

  assign pedestal = DATA_W'(sum >> LOG2);

endmodule

// File: rtl/pulse_window_capture.sv
// pulse_window_capture: trigger-gated sample window plus pulse-height measure.
//   clk           in   sample clock
//   reset_n       in   synchronous active-low reset
//   trigger       in   start request (level or pulse)
//   signal        in   DATA_W ADC sample
//   window_data   out  DATA_W windowed sample, 0 outside the window
//   window_valid  out  high while window_data carries a window sample
//   sample_idx    out  IDX_W index of the sample on window_data
//   pulse_height  out  DATA_W peak - pedestal clamped at 0, held
//   peak_idx      out  IDX_W index of the first maximum in the peak region
//   height_valid  out  one-cycle strobe when pulse_height/peak_idx update
//   busy          out  high in CAPTURE or HOLDOFF
//   dropped       out  8-bit saturating count of triggers seen while busy
// Build option: PULSE_PED_AVG_EN selects an averaged pedestal (mean of the
// last 2^PED_AVG_LOG2 idle samples); otherwise the pedestal is the last idle
// sample before the trigger.
//
// state   | meaning
// IDLE    | pedestal follows signal, waiting for trigger
// CAPTURE | streaming window samples, peak search over leading PEAK_LEN
// HOLDOFF | HOLDOFF_LEN dead cycles before re-arming
module pulse_window_capture
  import pulse_pkg::*;
#(
  parameter  int DATA_W       = 14,
  parameter  int WINDOW_LEN   = 500,
  parameter  int PEAK_LEN     = 31,
  parameter  int HOLDOFF_LEN  = 0,
  parameter  int PED_AVG_LOG2 = 2,
  localparam int IDX_W        = $clog2(WINDOW_LEN)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trigger,
  input  logic [DATA_W-1:0] signal,
  output logic [DATA_W-1:0] window_data,
  output logic              window_valid,
  output logic [IDX_W-1:0]  sample_idx,
  output logic [DATA_W-1:0] pulse_height,
  output logic [IDX_W-1:0]  peak_idx,
  output logic              height_valid,
  output logic              busy,
  output logic [DROP_W-1:0] dropped
);

  localparam int HOLD_W = (HOLDOFF_LEN > 1) ? $clog2(HOLDOFF_LEN) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WINDOW_LEN - 1);
  localparam logic [IDX_W-1:0]  PEAK_LAST = IDX_W'(PEAK_LEN - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);

  if (WINDOW_LEN < 2 || PEAK_LEN < 1 || PEAK_LEN > WINDOW_LEN ||
      HOLDOFF_LEN < 0 || PED_AVG_LOG2 < 0 || PED_AVG_LOG2 > 16) begin : g_bad_param
    $error("pulse_window_capture: illegal parameter combination");
  end

  state_t            state, state_next;
  logic              start, peak_done, win_end, drop_inc, ped_en;
  logic [DATA_W-1:0] peak, pedestal;
  logic [IDX_W-1:0]  peak_run_idx;
  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    peak_done  = 1'b0;
    win_end    = 1'b0;
    drop_inc   = 1'b0;
    ped_en     = 1'b0;
    case (state)
      IDLE: begin
        // The trigger sample belongs to the window, so it never reaches the pedestal.
        if (trigger) begin
          start      = 1'b1;
          state_next = CAPTURE;
        end else begin
          ped_en = 1'b1;
        end
      end
      CAPTURE: begin
        drop_inc  = trigger;
        peak_done = (sample_idx == PEAK_LAST);
        if (sample_idx == LAST_IDX) begin
          win_end    = 1'b1;
          state_next = (HOLDOFF_LEN > 0) ? HOLDOFF : IDLE;
        end
      end
      HOLDOFF: begin
        drop_inc = trigger;
        if (hold_cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      window_data  <= '0;
      window_valid <= 1'b0;
      sample_idx   <= '0;
      pulse_height <= '0;
      peak_idx     <= '0;
      height_valid <= 1'b0;
      dropped      <= '0;
      peak         <= '0;
      peak_run_idx <= '0;
      hold_cnt     <= '0;
    end else begin
      height_valid <= 1'b0;
      if (drop_inc && dropped != '1) dropped <= dropped + 1'b1;

      if (start) begin
        window_data  <= signal;
        window_valid <= 1'b1;
        sample_idx   <= '0;
        peak         <= signal;
        peak_run_idx <= '0;
      end else if (win_end) begin
        window_data  <= '0;
        window_valid <= 1'b0;
        sample_idx   <= '0;
      end else if (state == CAPTURE) begin
        window_data <= signal;
        sample_idx  <= sample_idx + 1'b1;
        // Incoming sample index is sample_idx+1; strict '>' keeps the earliest maximum.
        if (signal > peak && int'(sample_idx) < PEAK_LEN - 1) begin
          peak         <= signal;
          peak_run_idx <= sample_idx + 1'b1;
        end
      end

      if (peak_done) begin
        pulse_height <= DATA_W'(clamp_sub(CALC_W'(peak), CALC_W'(pedestal)));
        peak_idx     <= peak_run_idx;
        height_valid <= 1'b1;
      end

      if (win_end)                              hold_cnt <= HOLD_LOAD;
      else if (state == HOLDOFF && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
  end

`ifdef PULSE_PED_AVG_EN
  pedestal_avg #(
    .DATA_W (DATA_W),
    .LOG2   (PED_AVG_LOG2)
  ) u_pedestal_avg (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (ped_en),
    .sample   (signal),
    .pedestal (pedestal)
  );
`else
  always_ff @(posedge clk) begin
    if (!reset_n)    pedestal <= '0;
    else if (ped_en) pedestal <= signal;
  end
`endif

endmodule

// File: tb/tb_pulse_window_capture.sv
// Directed bench for pulse_window_capture: WINDOW_LEN=8, PEAK_LEN=4,
// HOLDOFF_LEN=3 main instance plus a PEAK_LEN=WINDOW_LEN instance (u_dut2)
// sharing the same stimulus.
module tb_pulse_window_capture;

  typedef logic [0:7][13:0] win_t;

`ifdef PULSE_PED_AVG_EN
  localparam int EXP_W4 = 394;
`else
  localparam int EXP_W4 = 388;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trigger;
  logic [13:0] signal;

  logic [13:0] window_data, pulse_height;
  logic        window_valid, height_valid, busy;
  logic [2:0]  sample_idx, peak_idx;
  logic [7:0]  dropped;

  logic [13:0] window_data2, pulse_height2;
  logic        window_valid2, height_valid2, busy2;
  logic [2:0]  sample_idx2, peak_idx2;
  logic [7:0]  dropped2;

  int n_chk = 0;
  int n_err = 0;

  win_t w1, w2, w3, w4, w5;

  always #5 clk = ~clk;

  pulse_window_capture #(
    .DATA_W(14), .WINDOW_LEN(8), .PEAK_LEN(4), .HOLDOFF_LEN(3), .PED_AVG_LOG2(2)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .signal(signal),
    .window_data(window_data), .window_valid(window_valid), .sample_idx(sample_idx),
    .pulse_height(pulse_height), .peak_idx(peak_idx), .height_valid(height_valid),
    .busy(busy), .dropped(dropped)
  );

  pulse_window_capture #(
    .DATA_W(14), .WINDOW_LEN(8), .PEAK_LEN(8), .HOLDOFF_LEN(0), .PED_AVG_LOG2(2)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .signal(signal),
    .window_data(window_data2), .window_valid(window_valid2), .sample_idx(sample_idx2),
    .pulse_height(pulse_height2), .peak_idx(peak_idx2), .height_valid(height_valid2),
    .busy(busy2), .dropped(dropped2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " window_data"},  window_data, 0);
    chk({tag, " window_valid"}, window_valid, 0);
    chk({tag, " sample_idx"},   sample_idx, 0);
    chk({tag, " pulse_height"}, pulse_height, 0);
    chk({tag, " peak_idx"},     peak_idx, 0);
    chk({tag, " height_valid"}, height_valid, 0);
    chk({tag, " busy"},         busy, 0);
    chk({tag, " dropped"},      dropped, 0);
  endtask

  // Edge 0 is the trigger edge, 1..7 stream the rest, 8 closes the window,
  // 9..11 are hold-off; the unit is IDLE again after edge 11.
  task automatic run_window(input int wid, input win_t s, input int exp_h, input int exp_pi,
                            input logic [11:0] drop_mask, input bit chk2);
    string t;
    for (int e = 0; e < 12; e++) begin
      signal  = (e < 8) ? s[e] : s[7];
      trigger = (e == 0) || drop_mask[e];
      tick();
      t = $sformatf("w%0d e%0d", wid, e);
      if (e < 8) begin
        chk({t, " window_valid"}, window_valid, 1);
        chk({t, " window_data"},  window_data, s[e]);
        chk({t, " sample_idx"},   sample_idx, e);
      end else begin
        chk({t, " window_valid"}, window_valid, 0);
        chk({t, " window_data"},  window_data, 0);
        chk({t, " sample_idx"},   sample_idx, 0);
      end
      chk({t, " height_valid"}, height_valid, (e == 4));
      if (e == 4 || e == 8) begin
        chk({t, " pulse_height"}, pulse_height, exp_h);
        chk({t, " peak_idx"},     peak_idx, exp_pi);
      end
      chk({t, " busy"}, busy, (e < 11));
      if (chk2 && e == 7) begin
        chk({t, " d2 height_valid"}, height_valid2, 0);
        chk({t, " d2 window_valid"}, window_valid2, 1);
      end
      if (chk2 && e == 8) begin
        chk({t, " d2 height_valid"}, height_valid2, 1);
        chk({t, " d2 window_valid"}, window_valid2, 0);
        chk({t, " d2 pulse_height"}, pulse_height2, 500);
        chk({t, " d2 peak_idx"},     peak_idx2, 5);
      end
    end
    trigger = 1'b0;
  endtask

  task automatic idle(input logic [13:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      signal  = v;
      trigger = 1'b0;
      tick();
    end
  endtask

  initial begin
    w1 = '{14'd100, 14'd300, 14'd500, 14'd200, 14'd150, 14'd600, 14'd110, 14'd105};
    w2 = '{14'd900, 14'd900, 14'd900, 14'd900, 14'd900, 14'd900, 14'd900, 14'd900};
    w3 = '{14'd900, 14'd900, 14'd900, 14'd950, 14'd990, 14'd900, 14'd900, 14'd900};
    w4 = '{14'd300, 14'd500, 14'd200, 14'd150, 14'd120, 14'd110, 14'd105, 14'd100};
    w5 = '{14'd210, 14'd400, 14'd700, 14'd300, 14'd200, 14'd200, 14'd200, 14'd200};

    // Reset with trigger toggling.
    reset_n = 1'b0;
    trigger = 1'b0;
    signal  = '0;
    for (int i = 0; i < 3; i++) begin
      trigger = i[0] ? 1'b0 : 1'b1;
      signal  = 14'($urandom_range(0, 16383));
      tick();
    end
    chk_all_zero("reset");
    chk("reset d2 window_valid", window_valid2, 0);
    chk("reset d2 busy", busy2, 0);

    reset_n = 1'b1;
    idle(14'd100, 5);
    chk("idle busy", busy, 0);
    chk("idle window_valid", window_valid, 0);
    chk("idle window_data", window_data, 0);

    // Main window; triggers at capture edge 4 and hold-off edge 10 are dropped.
    run_window(1, w1, 400, 2, 12'b0100_0001_0000, 1'b1);
    chk("w1 dropped", dropped, 2);

    // Accepted on the first IDLE edge; all-equal samples keep index 0.
    run_window(2, w2, 800, 0, 12'b0, 1'b0);
    chk("w2 dropped", dropped, 2);

    // Peak below pedestal clamps to zero; 990 at index 4 is outside the peak region.
    idle(14'd1000, 5);
    run_window(3, w3, 0, 3, 12'b0, 1'b0);

    // Pedestal: last idle sample (112) or mean of 100..112 (106).
    idle(14'd100, 1);
    idle(14'd104, 1);
    idle(14'd108, 1);
    idle(14'd112, 1);
    run_window(4, w4, EXP_W4, 1, 12'b0, 1'b0);

    // Reset at window sample 2 aborts without a height strobe.
    idle(14'd200, 4);
    trigger = 1'b1;
    signal  = 14'd250;
    tick();
    chk("abort start window_valid", window_valid, 1);
    trigger = 1'b0;
    signal  = 14'd260;
    tick();
    chk("abort sample_idx", sample_idx, 1);
    reset_n = 1'b0;
    signal  = 14'd800;
    tick();
    chk_all_zero("abort");
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      signal = 14'd200;
      tick();
      chk($sformatf("post-abort %0d height_valid", i), height_valid, 0);
      chk($sformatf("post-abort %0d window_valid", i), window_valid, 0);
    end
    run_window(5, w5, 500, 2, 12'b0, 1'b0);
    chk("w5 dropped", dropped, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
